// File: rtl/calcn_pkg.sv
// Shared encodings, state/op types and command decode helpers for the calcn_core calculator.
package calcn_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_SAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPND2 = 2'd1,
        ST_PEND  = 2'd2,
        ST_WAIT  = 2'd3
    } port_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_SHL = 2'd2,
        OP_SHR = 2'd3
    } alu_op_t;

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic alu_op_t cmd_to_op(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB: return OP_SUB;
            CMD_SHL: return OP_SHL;
            CMD_SHR: return OP_SHR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calcn_if.sv
// Request/response bundle between the NUM_PORTS clients and calcn_core.
interface calcn_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS*4-1:0]      req_cmd_in;
    logic [NUM_PORTS*DATA_W-1:0] req_data_in;
    logic [NUM_PORTS-1:0]        req_busy;
    logic [NUM_PORTS*2-1:0]      out_resp;
    logic [NUM_PORTS*DATA_W-1:0] out_data;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  req_busy,
        input  out_resp,
        input  out_data
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output req_busy,
        output out_resp,
        output out_data
    );
endinterface

// File: rtl/calcn_port_ctrl.sv
// Per-port command FSM: captures op/operands, raises busy while queued or in flight,
// and muxes either the tagged ALU result or an invalid-command error onto the port.
module calcn_port_ctrl
    import calcn_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] data,
    input  logic              gnt,
    input  logic              s2_hit,
    input  logic [1:0]        s2_resp,
    input  logic [DATA_W-1:0] s2_data,
    output logic              pend,
    output logic              busy,
    output alu_op_t           op,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] rdata
);

    port_state_t       state_r;
    port_state_t       state_s;
    alu_op_t           op_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic              inv_err_r;

    // State register, operand capture and one-shot invalid-command flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_ADD;
            opa_r     <= '0;
            opb_r     <= '0;
            inv_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            inv_err_r <= (state_r == ST_IDLE) && (cmd != CMD_NOP) && !cmd_is_valid(cmd);
            if ((state_r == ST_IDLE) && cmd_is_valid(cmd)) begin
                op_r  <= cmd_to_op(cmd);
                opa_r <= data;
            end
            if (state_r == ST_OPND2) begin
                opb_r <= data;
            end
        end
    end

    // Next-state logic; cmd is only looked at in IDLE, so busy ports drop commands.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_is_valid(cmd)) state_s = ST_OPND2;
                else                   state_s = ST_IDLE;
            end
            ST_OPND2: state_s = ST_PEND;
            ST_PEND: begin
                if (gnt) state_s = ST_WAIT;
                else     state_s = ST_PEND;
            end
            ST_WAIT: begin
                if (s2_hit) state_s = ST_IDLE;
                else        state_s = ST_WAIT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Response mux; the two sources are mutually exclusive by construction.
    always_comb begin
        resp  = RESP_NONE;
        rdata = '0;
        if ((state_r == ST_WAIT) && s2_hit) begin
            resp  = s2_resp;
            rdata = s2_data;
        end else if (inv_err_r) begin
            resp  = RESP_ERR;
            rdata = '0;
        end else begin
            resp  = RESP_NONE;
            rdata = '0;
        end
    end

    assign pend = (state_r == ST_PEND);
    assign busy = (state_r == ST_PEND) || (state_r == ST_WAIT);
    assign op   = op_r;
    assign opa  = opa_r;
    assign opb  = opb_r;

endmodule

// File: rtl/calcn_core.sv
// NUM_PORTS request ports sharing a two-stage ALU through a round-robin arbiter.
// Optional macro CALCN_SAT_EN turns add overflow / sub underflow into saturated responses.
module calcn_core
    import calcn_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic    c_clk,
    input  logic    reset_n,
    calcn_if.slave  bus
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SH_W  = $clog2(DATA_W);

    logic [NUM_PORTS-1:0] pend_s;
    logic [NUM_PORTS-1:0] busy_s;
    logic [NUM_PORTS-1:0] gnt_s;
    alu_op_t              op_s    [NUM_PORTS];
    logic [DATA_W-1:0]    opa_s   [NUM_PORTS];
    logic [DATA_W-1:0]    opb_s   [NUM_PORTS];
    logic [1:0]           resp_s  [NUM_PORTS];
    logic [DATA_W-1:0]    rdata_s [NUM_PORTS];

    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  gnt_idx_s;
    logic              gnt_valid_s;

    logic              s1_valid_r;
    logic [PTR_W-1:0]  s1_port_r;
    alu_op_t           s1_op_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;

    logic              s2_valid_r;
    logic [PTR_W-1:0]  s2_port_r;
    logic [1:0]        s2_resp_r;
    logic [DATA_W-1:0] s2_data_r;

    logic [DATA_W:0]   sum_s;
    logic [1:0]        alu_resp_s;
    logic [DATA_W-1:0] alu_data_s;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calcn_port_ctrl #(.DATA_W(DATA_W)) u_port (
            .clk     (c_clk),
            .rst_n   (reset_n),
            .cmd     (bus.req_cmd_in[4*p +: 4]),
            .data    (bus.req_data_in[DATA_W*p +: DATA_W]),
            .gnt     (gnt_s[p]),
            .s2_hit  (s2_valid_r && (s2_port_r == PTR_W'(p))),
            .s2_resp (s2_resp_r),
            .s2_data (s2_data_r),
            .pend    (pend_s[p]),
            .busy    (busy_s[p]),
            .op      (op_s[p]),
            .opa     (opa_s[p]),
            .opb     (opb_s[p]),
            .resp    (resp_s[p]),
            .rdata   (rdata_s[p])
        );
    end

    // Round-robin search over pending ports starting at the pointer.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        gnt_valid_s = 1'b0;
        gnt_idx_s   = ptr_r;
        gnt_s       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx_v = (int'(ptr_r) + i) % NUM_PORTS;
            if (!gnt_valid_s && pend_s[PTR_W'(idx_v)]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = PTR_W'(idx_v);
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
        if (gnt_valid_s) gnt_s[gnt_idx_s] = 1'b1;
        else             gnt_s = '0;
    end

    // Arbiter pointer and ALU stage 1 (operand/tag capture on grant).
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r      <= '0;
            s1_valid_r <= 1'b0;
            s1_port_r  <= '0;
            s1_op_r    <= OP_ADD;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
        end else begin
            s1_valid_r <= gnt_valid_s;
            if (gnt_valid_s) begin
                ptr_r     <= (gnt_idx_s == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
                s1_port_r <= gnt_idx_s;
                s1_op_r   <= op_s[gnt_idx_s];
                s1_a_r    <= opa_s[gnt_idx_s];
                s1_b_r    <= opb_s[gnt_idx_s];
            end
        end
    end

    // ALU datapath; shift amount uses only the low log2(DATA_W) bits of operand 2.
    always_comb begin
        sum_s      = {1'b0, s1_a_r} + {1'b0, s1_b_r};
        alu_resp_s = RESP_OK;
        alu_data_s = '0;
        case (s1_op_r)
            OP_ADD: begin
                if (sum_s[DATA_W]) begin
`ifdef CALCN_SAT_EN
                    alu_resp_s = RESP_SAT;
                    alu_data_s = '1;
`else
                    alu_resp_s = RESP_ERR;
                    alu_data_s = '0;
`endif
                end else begin
                    alu_data_s = sum_s[DATA_W-1:0];
                end
            end
            OP_SUB: begin
                if (s1_a_r < s1_b_r) begin
`ifdef CALCN_SAT_EN
                    alu_resp_s = RESP_SAT;
`else
                    alu_resp_s = RESP_ERR;
`endif
                    alu_data_s = '0;
                end else begin
                    alu_data_s = s1_a_r - s1_b_r;
                end
            end
            OP_SHL:  alu_data_s = s1_a_r << s1_b_r[SH_W-1:0];
            OP_SHR:  alu_data_s = s1_a_r >> s1_b_r[SH_W-1:0];
            default: alu_resp_s = RESP_ERR;
        endcase
    end

    // ALU stage 2: result, response code and destination tag.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_port_r  <= '0;
            s2_resp_r  <= RESP_NONE;
            s2_data_r  <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_port_r  <= s1_port_r;
            s2_resp_r  <= s1_valid_r ? alu_resp_s : RESP_NONE;
            s2_data_r  <= s1_valid_r ? alu_data_s : '0;
        end
    end

    // Pack per-port outputs onto the bus vectors.
    always_comb begin
        bus.req_busy = '0;
        bus.out_resp = '0;
        bus.out_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.req_busy[p]                  = busy_s[p];
            bus.out_resp[2*p +: 2]           = resp_s[p];
            bus.out_data[DATA_W*p +: DATA_W] = rdata_s[p];
        end
    end

endmodule

// File: tb/tb_calcn_core.sv
// Directed self-checking bench for calcn_core (NUM_PORTS=4, DATA_W=32).
module tb_calcn_core;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   chk_cnt;

    calcn_if #(.NUM_PORTS(4), .DATA_W(32)) bus ();

    calcn_core #(.NUM_PORTS(4), .DATA_W(32)) dut (
        .c_clk   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] res;
        string       name;
    } vec_t;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] data);
        bus.req_cmd_in[4*p +: 4]   = cmd;
        bus.req_data_in[32*p +: 32] = data;
    endtask

    task automatic clear_all();
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
    endtask

    task automatic do_reset();
        clear_all();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    function automatic logic [1:0] resp_of(input int p);
        return bus.out_resp[2*p +: 2];
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return bus.out_data[32*p +: 32];
    endfunction

    task automatic test_reset();
        clear_all();
        rst_n = 1'b0;
        next_cycle();
        chk_cnt++;
        if (bus.req_busy !== 4'h0) $display("FAIL reset_busy got=%h exp=0", bus.req_busy);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_resp !== 8'h00) $display("FAIL reset_resp got=%h exp=0", bus.out_resp);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_data !== 128'h0) $display("FAIL reset_data got=%h exp=0", bus.out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_add_timing();
        logic exp_busy;
        logic [1:0] exp_resp;
        logic [31:0] exp_data;
        do_reset();
        set_port(0, 4'd1, 32'h1);
        next_cycle();
        set_port(0, 4'd0, 32'h01FF_FFFF);
        next_cycle();
        clear_all();
        for (int c = 2; c <= 5; c++) begin
            exp_busy = (c <= 4);
            exp_resp = (c == 4) ? 2'd1 : 2'd0;
            exp_data = (c == 4) ? 32'h0200_0000 : 32'h0;
            chk_cnt++;
            if (bus.req_busy[0] !== exp_busy)
                $display("FAIL add_busy T+%0d got=%b exp=%b", c, bus.req_busy[0], exp_busy);
            else pass_cnt++;
            chk_cnt++;
            if (resp_of(0) !== exp_resp || data_of(0) !== exp_data)
                $display("FAIL add_resp T+%0d got=%0d/%h exp=%0d/%h", c, resp_of(0), data_of(0), exp_resp, exp_data);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_arith();
        vec_t vecs [8];
`ifdef CALCN_SAT_EN
        vecs[0] = '{4'd1, 32'hFFFF_FFFF, 32'h1, 2'd3, 32'hFFFF_FFFF, "add_ovf"};
        vecs[1] = '{4'd2, 32'h1, 32'hF, 2'd3, 32'h0, "sub_unf"};
`else
        vecs[0] = '{4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, "add_ovf"};
        vecs[1] = '{4'd2, 32'h1, 32'hF, 2'd2, 32'h0, "sub_unf"};
`endif
        vecs[2] = '{4'd2, 32'h5, 32'h5, 2'd1, 32'h0, "sub_eq"};
        vecs[3] = '{4'd2, 32'h10, 32'h3, 2'd1, 32'hD, "sub_ok"};
        vecs[4] = '{4'd5, 32'h1, 32'h21, 2'd1, 32'h2, "shl_mask"};
        vecs[5] = '{4'd6, 32'h8000_0000, 32'h1F, 2'd1, 32'h1, "shr_31"};
        vecs[6] = '{4'd6, 32'h1234, 32'h20, 2'd1, 32'h1234, "shr_zero_amt"};
        vecs[7] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, "add_max"};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            set_port(0, vecs[v].cmd, vecs[v].a);
            next_cycle();
            set_port(0, 4'd0, vecs[v].b);
            next_cycle();
            clear_all();
            next_cycle();
            next_cycle();
            chk_cnt++;
            if (resp_of(0) !== vecs[v].resp || data_of(0) !== vecs[v].res)
                $display("FAIL %s got=%0d/%h exp=%0d/%h", vecs[v].name, resp_of(0), data_of(0), vecs[v].resp, vecs[v].res);
            else pass_cnt++;
            next_cycle();
            chk_cnt++;
            if (resp_of(0) !== 2'd0 || bus.req_busy[0] !== 1'b0)
                $display("FAIL %s_after got=%0d busy=%b exp=0 busy=0", vecs[v].name, resp_of(0), bus.req_busy[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_invalid();
        do_reset();
        set_port(0, 4'd3, 32'hABCD);
        next_cycle();
        clear_all();
        chk_cnt++;
        if (resp_of(0) !== 2'd2 || data_of(0) !== 32'h0 || bus.req_busy[0] !== 1'b0)
            $display("FAIL invalid_resp got=%0d/%h busy=%b exp=2/0 busy=0", resp_of(0), data_of(0), bus.req_busy[0]);
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (resp_of(0) !== 2'd0 || bus.req_busy[0] !== 1'b0)
            $display("FAIL invalid_once got=%0d busy=%b exp=0 busy=0", resp_of(0), bus.req_busy[0]);
        else pass_cnt++;
        set_port(1, 4'd0, 32'h55);
        next_cycle();
        next_cycle();
        chk_cnt++;
        if (bus.out_resp !== 8'h00 || bus.req_busy !== 4'h0)
            $display("FAIL nop_silent got=%h busy=%h exp=0 busy=0", bus.out_resp, bus.req_busy);
        else pass_cnt++;
        clear_all();
    endtask

    task automatic test_busy_drop();
        do_reset();
        set_port(0, 4'd1, 32'h10);
        next_cycle();
        set_port(0, 4'd0, 32'h20);
        next_cycle();
        set_port(0, 4'd1, 32'h77);
        next_cycle();
        next_cycle();
        chk_cnt++;
        if (resp_of(0) !== 2'd1 || data_of(0) !== 32'h30)
            $display("FAIL drop_first got=%0d/%h exp=1/30", resp_of(0), data_of(0));
        else pass_cnt++;
        clear_all();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            chk_cnt++;
            if (resp_of(0) !== 2'd0 || bus.req_busy[0] !== 1'b0)
                $display("FAIL drop_quiet c%0d got=%0d busy=%b exp=0 busy=0", c, resp_of(0), bus.req_busy[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'(p));
        next_cycle();
        for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h1);
        next_cycle();
        clear_all();
        chk_cnt++;
        if (bus.req_busy !== 4'hF) $display("FAIL contend_busy got=%h exp=f", bus.req_busy);
        else pass_cnt++;
        for (int c = 2; c <= 8; c++) begin
            for (int p = 0; p < 4; p++) begin
                exp_resp = (c == 4 + p) ? 2'd1 : 2'd0;
                exp_data = (c == 4 + p) ? 32'(p + 1) : 32'h0;
                chk_cnt++;
                if (resp_of(p) !== exp_resp || data_of(p) !== exp_data)
                    $display("FAIL contend p%0d T+%0d got=%0d/%h exp=%0d/%h", p, c, resp_of(p), data_of(p), exp_resp, exp_data);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_port(2, 4'd1, 32'h2);
        next_cycle();
        set_port(2, 4'd0, 32'h2);
        next_cycle();
        clear_all();
        next_cycle();
        next_cycle();
        chk_cnt++;
        if (resp_of(2) !== 2'd1 || data_of(2) !== 32'h4)
            $display("FAIL rr_p2 got=%0d/%h exp=1/4", resp_of(2), data_of(2));
        else pass_cnt++;
        next_cycle();
        set_port(0, 4'd1, 32'h10);
        set_port(3, 4'd1, 32'h30);
        next_cycle();
        set_port(0, 4'd0, 32'h1);
        set_port(3, 4'd0, 32'h3);
        next_cycle();
        clear_all();
        next_cycle();
        next_cycle();
        chk_cnt++;
        if (resp_of(3) !== 2'd1 || data_of(3) !== 32'h33 || resp_of(0) !== 2'd0)
            $display("FAIL rr_first got=p3 %0d/%h p0 %0d exp=p3 1/33 p0 0", resp_of(3), data_of(3), resp_of(0));
        else pass_cnt++;
        next_cycle();
        chk_cnt++;
        if (resp_of(0) !== 2'd1 || data_of(0) !== 32'h11 || resp_of(3) !== 2'd0)
            $display("FAIL rr_second got=p0 %0d/%h p3 %0d exp=p0 1/11 p3 0", resp_of(0), data_of(0), resp_of(3));
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(2, 4'd2, 32'h9);
        next_cycle();
        set_port(2, 4'd0, 32'h4);
        next_cycle();
        clear_all();
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.out_resp !== 8'h00 || bus.out_data !== 128'h0 || bus.req_busy !== 4'h0)
            $display("FAIL midrst_outputs got=%h/%h busy=%h exp=0/0 busy=0", bus.out_resp, bus.out_data, bus.req_busy);
        else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_cnt++;
            if (resp_of(2) !== 2'd0 || bus.req_busy[2] !== 1'b0)
                $display("FAIL midrst_quiet c%0d got=%0d busy=%b exp=0 busy=0", c, resp_of(2), bus.req_busy[2]);
            else pass_cnt++;
            next_cycle();
        end
        set_port(2, 4'd2, 32'h9);
        next_cycle();
        set_port(2, 4'd0, 32'h4);
        next_cycle();
        clear_all();
        next_cycle();
        next_cycle();
        chk_cnt++;
        if (resp_of(2) !== 2'd1 || data_of(2) !== 32'h5)
            $display("FAIL midrst_recover got=%0d/%h exp=1/5", resp_of(2), data_of(2));
        else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n    = 1'b0;
        clear_all();
        @(negedge clk);
        test_reset();
        test_add_timing();
        test_arith();
        test_invalid();
        test_busy_drop();
        test_contention();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
